// File: rtl/audio_packetizer.sv
// audio_packetizer: multichannel PCM-to-frame packetizer.
// Each pcm_stb is serialised (NCH channels x SBYTES bytes, little-endian per channel) into the
// payload area of one of two ping-pong BRAM banks; a full bank is handed to the Ethernet sender.
// Optional feature macro: AUDIO_PKT_SEQ_EN (16-bit frame sequence number at HDR_LEN).
`timescale 1ns/1ps
module audio_packetizer #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned SBYTES    = 2,
  parameter int unsigned SPF       = 28,
  parameter int unsigned HDR_LEN   = 14,
  parameter int unsigned BANK_SIZE = 512,
  parameter int unsigned AW        = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pcm_stb,
  input  logic [NCH*SBYTES*8-1:0] pcm_data,
  input  logic                    eth_busy,
  output logic                    eth_start,
  output logic                    tx_bank,
  output logic                    bram_wr_en,
  output logic [AW-1:0]           bram_wr_addr,
  output logic [7:0]              bram_wr_data,
  output logic [15:0]             drop_cnt
);

  localparam int unsigned BPS = NCH * SBYTES;
`ifdef AUDIO_PKT_SEQ_EN
  localparam int unsigned PAY_OFF = HDR_LEN + 2;
`else
  localparam int unsigned PAY_OFF = HDR_LEN;
`endif
  localparam int unsigned SIW = $clog2(SPF + 1);
  localparam int unsigned BIW = $clog2(BPS + 1);

  typedef enum logic [2:0] {StIdle, StWrite, StEos, StFrame, StSeqHi} state_e;

  state_e             state;
  logic [BPS*8-1:0]   shadow;
  logic               wr_bank;
  logic [SIW-1:0]     sample_idx;
  logic [BIW-1:0]     byte_idx;
  logic               pending;
  logic               inflight;
  logic               busy_seen;
  logic [1:0]         low_cnt;
`ifdef AUDIO_PKT_SEQ_EN
  logic [15:0]        seq;
`endif

  logic [AW-1:0] bank_base;
  logic [AW-1:0] pay_addr;
  logic [7:0]    cur_byte;
  logic          other_free;
  logic          stb_drop;
  logic          frame_drop;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  // Address/data for the current byte and the saturating drop-counter increment.
  always_comb begin
    bank_base  = wr_bank ? AW'(BANK_SIZE) : '0;
    pay_addr   = bank_base + AW'(PAY_OFF) + AW'(sample_idx) * AW'(BPS) + AW'(byte_idx);
    cur_byte   = 8'(shadow >> {byte_idx, 3'b000});
    // The pending/inflight bank is always the one not being filled.
    other_free = !pending && !inflight;
    stb_drop   = pcm_stb && (state != StIdle);
    frame_drop = (state == StFrame) && !other_free;
    drop_inc   = {1'b0, stb_drop} + {1'b0, frame_drop};
    drop_sum   = {1'b0, drop_cnt} + {15'b0, drop_inc};
  end

  // Writer FSM plus transmit hand-off; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      shadow       <= '0;
      wr_bank      <= 1'b0;
      sample_idx   <= '0;
      byte_idx     <= '0;
      pending      <= 1'b0;
      inflight     <= 1'b0;
      busy_seen    <= 1'b0;
      low_cnt      <= 2'd0;
      eth_start    <= 1'b0;
      tx_bank      <= 1'b0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= 8'd0;
      drop_cnt     <= 16'd0;
`ifdef AUDIO_PKT_SEQ_EN
      seq          <= 16'd0;
`endif
    end else begin
      bram_wr_en <= 1'b0;
      eth_start  <= 1'b0;
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      unique case (state)
        StIdle: begin
          if (pcm_stb) begin
            // Byte 0 goes out straight from the input; the rest from the shadow copy.
            shadow       <= pcm_data;
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= pay_addr;
            bram_wr_data <= pcm_data[7:0];
            if (BPS == 1) begin
              state <= StEos;
            end else begin
              byte_idx <= BIW'(1);
              state    <= StWrite;
            end
          end
        end
        StWrite: begin
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= pay_addr;
          bram_wr_data <= cur_byte;
          if (byte_idx == BIW'(BPS - 1)) begin
            byte_idx <= '0;
            state    <= StEos;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        StEos: begin
          if (sample_idx == SIW'(SPF - 1)) begin
            state <= StFrame;
          end else begin
            sample_idx <= sample_idx + 1'b1;
            state      <= StIdle;
          end
        end
        StFrame: begin
          sample_idx <= '0;
          state      <= StIdle;
          if (other_free) begin
`ifdef AUDIO_PKT_SEQ_EN
            bram_wr_en   <= 1'b1;
            bram_wr_addr <= bank_base + AW'(HDR_LEN);
            bram_wr_data <= seq[7:0];
            state        <= StSeqHi;
`else
            pending <= 1'b1;
            wr_bank <= ~wr_bank;
`endif
          end
          // Otherwise the frame is dropped and the same bank is refilled.
        end
        StSeqHi: begin
`ifdef AUDIO_PKT_SEQ_EN
          bram_wr_en   <= 1'b1;
          bram_wr_addr <= bank_base + AW'(HDR_LEN + 1);
          bram_wr_data <= seq[15:8];
          pending      <= 1'b1;
          wr_bank      <= ~wr_bank;
          seq          <= seq + 16'd1;
`endif
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase

      // Start/release of the transmit bank runs alongside the writer.
      if (pending && !inflight && !eth_busy) begin
        eth_start <= 1'b1;
        tx_bank   <= ~wr_bank;
        pending   <= 1'b0;
        inflight  <= 1'b1;
        busy_seen <= 1'b0;
        low_cnt   <= 2'd0;
      end else if (inflight) begin
        if (eth_busy) begin
          busy_seen <= 1'b1;
        end else if (busy_seen || low_cnt == 2'd2) begin
          // Falling edge of busy, or the sender never picked the start up.
          inflight <= 1'b0;
        end else begin
          low_cnt <= low_cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_packetizer.sv
// Self-checking bench for audio_packetizer at default parameters.
`timescale 1ns/1ps
module tb_audio_packetizer;

  localparam int NCH = 2, SBYTES = 2, SPF = 28, HDR_LEN = 14, BANK = 512, AW = 10;
  localparam int BPS = NCH * SBYTES;
`ifdef AUDIO_PKT_SEQ_EN
  localparam int PAY = HDR_LEN + 2;
  localparam int FEXTRA = 2;
`else
  localparam int PAY = HDR_LEN;
  localparam int FEXTRA = 1;
`endif

  logic          clk, rst_n, pcm_stb, eth_busy;
  logic [31:0]   pcm_data;
  logic          eth_start, tx_bank, bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [7:0]    bram_wr_data;
  logic [15:0]   drop_cnt;

  audio_packetizer #(
    .NCH(NCH), .SBYTES(SBYTES), .SPF(SPF), .HDR_LEN(HDR_LEN), .BANK_SIZE(BANK), .AW(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pcm_stb(pcm_stb), .pcm_data(pcm_data), .eth_busy(eth_busy),
    .eth_start(eth_start), .tx_bank(tx_bank), .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  typedef struct {
    logic stb; logic [31:0] data; logic en; logic [AW-1:0] addr; logic [7:0] dat; logic [15:0] drop;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   sb = 0;
  wr_t  wq[$];
  logic sq[$];

  // Observed write stream and start pulses.
  always @(negedge clk) begin
    if (bram_wr_en) wq.push_back({bram_wr_addr, bram_wr_data});
    if (eth_start) sq.push_back(tx_bank);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic stb, input logic [31:0] d, input logic en,
                               input int addr, input int dat, input int drop);
    vec_t v;
    v.stb = stb; v.data = d; v.en = en; v.addr = AW'(addr); v.dat = 8'(dat); v.drop = 16'(drop);
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    pcm_stb = 1'b0;
    pcm_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_sample(input logic [31:0] d);
    @(posedge clk);
    #1 pcm_stb = 1'b1; pcm_data = d;
    @(posedge clk);
    #1 pcm_stb = 1'b0;
    repeat (BPS + 3) @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < SPF; i++) send_sample($urandom);
  endtask

  task automatic wait_starts(input string name, input int target);
    for (int i = 0; i < 40 && (sq.size() - sb) < target; i++) @(negedge clk);
    chk(name, sq.size() - sb, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[12];
    eth_busy = 1'b0;
    rst_n = 1'b0; pcm_stb = 1'b0; pcm_data = '0;
    #3;
    chk("rst_eth_start", eth_start, 0);
    chk("rst_tx_bank", tx_bank, 0);
    chk("rst_wr_en", bram_wr_en, 0);
    chk("rst_addr", bram_wr_addr, 0);
    chk("rst_data", bram_wr_data, 0);
    chk("rst_drop", drop_cnt, 0);
    do_reset();

    // Single strobe byte order, then a back-to-back strobe that must be dropped.
    tv[0]  = mkv(1, 32'hA1B2C3D4, 0, 0, 0, 0);
    tv[1]  = mkv(0, 0, 1, PAY + 0, 8'hD4, 0);
    tv[2]  = mkv(0, 0, 1, PAY + 1, 8'hC3, 0);
    tv[3]  = mkv(0, 0, 1, PAY + 2, 8'hB2, 0);
    tv[4]  = mkv(0, 0, 1, PAY + 3, 8'hA1, 0);
    tv[5]  = mkv(0, 0, 0, 0, 0, 0);
    tv[6]  = mkv(1, 32'h11223344, 0, 0, 0, 0);
    tv[7]  = mkv(1, 32'h55667788, 1, PAY + 4, 8'h44, 0);
    tv[8]  = mkv(0, 0, 1, PAY + 5, 8'h33, 1);
    tv[9]  = mkv(0, 0, 1, PAY + 6, 8'h22, 1);
    tv[10] = mkv(0, 0, 1, PAY + 7, 8'h11, 1);
    tv[11] = mkv(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 pcm_stb = tv[i].stb; pcm_data = tv[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_en", i), bram_wr_en, tv[i].en);
      if (tv[i].en) begin
        chk($sformatf("vec%0d_addr", i), bram_wr_addr, tv[i].addr);
        chk($sformatf("vec%0d_data", i), bram_wr_data, tv[i].dat);
      end
      chk($sformatf("vec%0d_drop", i), drop_cnt, tv[i].drop);
      chk($sformatf("vec%0d_start", i), eth_start, 0);
    end

    // Random strobes against a transaction-level model with an always-ready sender.
    begin
      wr_t  ew[$];
      logic eb[$];
      int   edge_n = 0, free_at = 0, idx = 0, exp_drop = 0, wb;
      logic bank = 1'b0;
      logic [15:0] seqm = 16'd0;
      logic stb;
      logic [31:0] d;
      do_reset();
      wb = wq.size();
      sb = sq.size();
      for (int k = 0; k < 2000; k++) begin
        @(posedge clk);
        edge_n++;
        #1;
        stb = ($urandom_range(0, 2) == 0);
        d = $urandom;
        pcm_stb = stb;
        pcm_data = d;
        if (stb) begin
          if (edge_n + 1 >= free_at) begin
            for (int b = 0; b < BPS; b++)
              ew.push_back({AW'(int'(bank) * BANK + PAY + idx * BPS + b), 8'(d >> (8 * b))});
            idx++;
            if (idx == SPF) begin
`ifdef AUDIO_PKT_SEQ_EN
              ew.push_back({AW'(int'(bank) * BANK + HDR_LEN), seqm[7:0]});
              ew.push_back({AW'(int'(bank) * BANK + HDR_LEN + 1), seqm[15:8]});
              seqm++;
`endif
              eb.push_back(bank);
              bank = ~bank;
              idx = 0;
              free_at = edge_n + 1 + BPS + 1 + FEXTRA;
            end else begin
              free_at = edge_n + 1 + BPS + 1;
            end
          end else begin
            exp_drop++;
          end
        end
      end
      #1 pcm_stb = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("rand_nwrites", wq.size() - wb, ew.size());
      for (int i = 0; i < ew.size() && wb + i < wq.size(); i++)
        chk($sformatf("rand_wr%0d", i), wq[wb + i], ew[i]);
      chk("rand_nstarts", sq.size() - sb, eb.size());
      for (int i = 0; i < eb.size() && sb + i < sq.size(); i++)
        chk($sformatf("rand_bank%0d", i), sq[sb + i], eb[i]);
      chk("rand_drop", drop_cnt, exp_drop);
    end

    // Sender held busy: second frame dropped, then release and falling-edge free.
    begin
      int wb;
      eth_busy = 1'b1;
      do_reset();
      sb = sq.size();
      send_frame();
      chk("busy_no_start0", sq.size() - sb, 0);
      wb = wq.size();
      send_sample(32'h0BADCAFE);
      chk("bank1_nbytes", wq.size() - wb, BPS);
      if (wq.size() - wb >= 1) begin
        chk("bank1_first_addr", wq[wb].addr, BANK + PAY);
        chk("bank1_first_data", wq[wb].data, 8'hFE);
      end
      for (int i = 1; i < SPF; i++) send_sample($urandom);
      chk("busy_frame_drop", drop_cnt, 1);
      chk("busy_no_start1", sq.size() - sb, 0);
      eth_busy = 1'b0;
      wait_starts("release_start", 1);
      chk("release_tx_bank", tx_bank, 0);
      eth_busy = 1'b1;
      send_frame();
      chk("inflight_frame_drop", drop_cnt, 2);
      chk("inflight_no_start", sq.size() - sb, 1);
      chk("tx_bank_stable", tx_bank, 0);
      eth_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      send_frame();
      wait_starts("second_start", 2);
      chk("second_tx_bank", tx_bank, 1);
      chk("final_drop", drop_cnt, 2);
    end

    // Reset in the middle of a frame: writes stop, nothing is transmitted.
    begin
      int wb;
      eth_busy = 1'b0;
      do_reset();
      sb = sq.size();
      for (int i = 0; i < SPF - 1; i++) send_sample($urandom);
      @(posedge clk);
      #1 pcm_stb = 1'b1; pcm_data = 32'hCAFEF00D;
      @(posedge clk);
      #1 pcm_stb = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", bram_wr_en, 0);
      chk("midrst_drop", drop_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("midrst_no_start", sq.size() - sb, 0);
      wb = wq.size();
      send_sample(32'h01020304);
      chk("midrst_nbytes", wq.size() - wb, BPS);
      if (wq.size() - wb >= 1) begin
        chk("midrst_addr", wq[wb].addr, PAY);
        chk("midrst_data", wq[wb].data, 8'h04);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
